regfile_scoreboard: RTL and testbench

- 32-entry x WIDTH-bit register file for the CPU decode/writeback boundary.
- Two combinational read ports with same-cycle write-to-read bypass; one synchronous write port; register 0 hardwired to zero.
- Integrated scoreboard tracks registers with an outstanding writer.
- Raises stall to the issue stage on RAW or WAW hazards until writeback clears the hazard.

---
 rtl/regfile_scoreboard.sv | 121 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//
// 32-entry register file for the decode/writeback boundary, with an integrated
// busy-bit scoreboard that stalls issue on RAW and WAW hazards.
//
// Ports:
//   clk            clock; every state update happens on its rising edge
//   rst_n          asynchronous active-low reset; clears registers, busy bits, count
//   ra1, ra2       read addresses
//   rd1, rd2       combinational read data, with same-cycle writeback bypass
//   wa, wd         writeback address and data
//   wrenable       writeback strobe; clears the busy bit of wa
//   issue_valid    issue stage presents an instruction this cycle
//   issue_dest     destination register of the issuing instruction
//   issue_has_dest issuing instruction writes a register
//   stall          hazard on a source or destination; issue must hold
//   pending_count  number of registers currently marked busy
//
// Register 0 always reads 0, and it is never marked busy.

module regfile_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic              wrenable,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              issue_has_dest,
    output logic              stall,
    output logic [ADDR_W:0]   pending_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ebusy;
    logic [ADDR_W:0]  pending_q;

    logic wr_nz;
    logic set_en;
    logic set_eff;
    logic clr_eff;

    assign wr_nz = wrenable && (wa != '0);

    // A register being written back this cycle is free: the reader gets the
    // value through the bypass, so it must not hold issue.
    always_comb begin
        ebusy = busy;
        if (wrenable) begin
            ebusy[wa] = 1'b0;
        end
    end

    assign stall = issue_valid &&
                   (ebusy[ra1] || ebusy[ra2] || (issue_has_dest && ebusy[issue_dest]));

    assign set_en = issue_valid && issue_has_dest && (issue_dest != '0) && !stall;

    // Count deltas only for bits that actually change. When set and clear hit
    // the same register the set wins, so a busy register stays busy and the
    // clear contributes nothing.
    assign set_eff = set_en && !busy[issue_dest];
    assign clr_eff = wr_nz && busy[wa] && !(set_en && (issue_dest == wa));

    always_comb begin
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wrenable && (wa == ra1)) begin
            rd1 = wd;
        end else begin
            rd1 = regs[ra1];
        end
    end

    always_comb begin
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wrenable && (wa == ra2)) begin
            rd2 = wd;
        end else begin
            rd2 = regs[ra2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            pending_q <= '0;
        end else begin
            if (wr_nz) begin
                regs[wa] <= wd;
                busy[wa] <= 1'b0;
            end
            // Placed after the clear so the set takes precedence on a collision.
            if (set_en) begin
                busy[issue_dest] <= 1'b1;
            end
            case ({set_eff, clr_eff})
                2'b10:   pending_q <= pending_q + (ADDR_W+1)'(1);
                2'b01:   pending_q <= pending_q - (ADDR_W+1)'(1);
                default: pending_q <= pending_q;
            endcase
        end
    end

    assign pending_count = pending_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//
// Self-checking bench for regfile_scoreboard. Each cycle the bench pushes the
// values a behavioural model predicts (plus hand-derived constants for the
// directed cases) onto a scoreboard queue, then pops and compares them against
// the DUT outputs shortly before the next rising edge.

module tb_regfile_scoreboard;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] ra1, ra2, wa, issue_dest;
    logic [WIDTH-1:0]  rd1, rd2, wd;
    logic              wrenable, issue_valid, issue_has_dest, stall;
    logic [ADDR_W:0]   pending_count;

    regfile_scoreboard #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ra1            (ra1),
        .ra2            (ra2),
        .rd1            (rd1),
        .rd2            (rd2),
        .wa             (wa),
        .wd             (wd),
        .wrenable       (wrenable),
        .issue_valid    (issue_valid),
        .issue_dest     (issue_dest),
        .issue_has_dest (issue_has_dest),
        .stall          (stall),
        .pending_count  (pending_count)
    );

    always #5 clk = ~clk;

    localparam int K_RD1 = 0, K_RD2 = 1, K_STALL = 2, K_CNT = 3;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] mregs [32];
    logic [31:0] mbusy;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic push_exp(input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_RD1:   obs = rd1;
                K_RD2:   obs = rd2;
                K_STALL: obs = {31'b0, stall};
                default: obs = {26'b0, pending_count};
            endcase
            check_val(e.tag, obs, e.exp);
        end
    endtask

    function automatic logic m_ebusy(input logic [4:0] a);
        return mbusy[a] && !(wrenable && wa == a);
    endfunction

    function automatic logic m_stall();
        return issue_valid &&
               (m_ebusy(ra1) || m_ebusy(ra2) || (issue_has_dest && m_ebusy(issue_dest)));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wrenable && wa == a) return wd;
        return mregs[a];
    endfunction

    function automatic logic [31:0] m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
        return 32'(c);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mbusy = 32'h0;
    endtask

    task automatic idle();
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; wrenable = 1'b0;
        issue_valid = 1'b0; issue_dest = '0; issue_has_dest = 1'b0;
    endtask

    task automatic issue(input logic [4:0] s1, input logic [4:0] s2,
                         input logic has_dest, input logic [4:0] dest);
        issue_valid = 1'b1; ra1 = s1; ra2 = s2;
        issue_has_dest = has_dest; issue_dest = dest;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wrenable = 1'b1; wa = a; wd = d;
    endtask

    // Called in the clock-low phase with inputs already driven. Compares model
    // and any directed expectations, then advances the model across the edge.
    task automatic cycle(input string tag);
        logic st;
        #1;
        push_exp({tag, ".rd1"},   K_RD1,   m_read(ra1));
        push_exp({tag, ".rd2"},   K_RD2,   m_read(ra2));
        push_exp({tag, ".stall"}, K_STALL, {31'b0, m_stall()});
        push_exp({tag, ".count"}, K_CNT,   m_count());
        drain();
        st = m_stall();
        if (wrenable && wa != 0) begin
            mregs[wa] = wd;
            mbusy[wa] = 1'b0;
        end
        if (issue_valid && issue_has_dest && issue_dest != 0 && !st) mbusy[issue_dest] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        push_exp("init.count", K_CNT, 32'd0);
        cycle("init");
        rst_n = 1'b1;
        cycle("init_rel");

        // Fill r1..r31 and mark every one busy (set wins over same-cycle clear).
        for (int i = 1; i < 32; i++) begin
            idle();
            wb(5'(i), 32'hA000_0000 | 32'(i));
            issue(5'd0, 5'd0, 1'b1, 5'(i));
            cycle("fill");
        end
        idle();
        push_exp("fill.count", K_CNT, 32'd31);
        cycle("fill_done");

        // Asynchronous reset asserted between edges; outputs must clear at once.
        #2;
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            push_exp("rst.rd1", K_RD1, 32'h0);
            push_exp("rst.rd2", K_RD2, 32'h0);
            drain();
        end
        push_exp("rst.count", K_CNT, 32'd0);
        drain();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        cycle("post_rst");

        // Write, read back, then bypass.
        wb(5'd5, 32'hDEADBEEF);
        cycle("wr5");
        idle(); ra1 = 5'd5;
        push_exp("rd5", K_RD1, 32'hDEADBEEF);
        cycle("rd5");
        idle(); ra2 = 5'd5; wb(5'd5, 32'h12345678);
        push_exp("bypass5", K_RD2, 32'h12345678);
        cycle("byp5");
        idle(); ra1 = 5'd5;
        push_exp("rd5_new", K_RD1, 32'h12345678);
        cycle("rd5b");

        // Register 0.
        idle(); wb(5'd0, 32'hFFFFFFFF);
        push_exp("r0_bypass", K_RD1, 32'h0);
        cycle("wr0");
        idle();
        push_exp("r0_read", K_RD1, 32'h0);
        issue(5'd0, 5'd0, 1'b1, 5'd0);
        push_exp("r0_issue.stall", K_STALL, 32'd0);
        cycle("iss0");
        idle();
        push_exp("r0_issue.count", K_CNT, 32'd0);
        cycle("iss0b");

        // RAW on r7.
        issue(5'd0, 5'd0, 1'b1, 5'd7);
        push_exp("raw.set_stall", K_STALL, 32'd0);
        cycle("raw0");
        for (int i = 0; i < 3; i++) begin
            idle(); issue(5'd7, 5'd0, 1'b0, 5'd0);
            push_exp("raw.stall", K_STALL, 32'd1);
            push_exp("raw.count", K_CNT, 32'd1);
            cycle("raw");
        end
        idle(); issue(5'd7, 5'd0, 1'b0, 5'd0); wb(5'd7, 32'h55);
        push_exp("raw.wb_stall", K_STALL, 32'd0);
        push_exp("raw.wb_rd1", K_RD1, 32'h55);
        cycle("raw_wb");
        idle();
        push_exp("raw.count_after", K_CNT, 32'd0);
        cycle("raw_done");

        // WAW and count.
        issue(5'd0, 5'd0, 1'b1, 5'd3); cycle("waw3");
        issue(5'd0, 5'd0, 1'b1, 5'd4); cycle("waw4");
        issue(5'd0, 5'd0, 1'b1, 5'd9); cycle("waw9");
        issue(5'd0, 5'd0, 1'b1, 5'd4);
        push_exp("waw.count3", K_CNT, 32'd3);
        push_exp("waw.stall", K_STALL, 32'd1);
        cycle("waw_hold");
        idle(); issue(5'd0, 5'd0, 1'b1, 5'd4); wb(5'd4, 32'h44);
        push_exp("waw.wb_stall", K_STALL, 32'd0);
        cycle("waw_wb");
        idle(); issue(5'd4, 5'd0, 1'b0, 5'd0);
        push_exp("waw.count_keep", K_CNT, 32'd3);
        push_exp("waw.busy4", K_STALL, 32'd1);
        cycle("waw_after");

        // Untracked writeback.
        idle(); wb(5'd12, 32'hCAFE0012);
        cycle("untr");
        idle(); issue(5'd12, 5'd0, 1'b0, 5'd0);
        push_exp("untr.stall", K_STALL, 32'd0);
        push_exp("untr.rd1", K_RD1, 32'hCAFE0012);
        push_exp("untr.count", K_CNT, 32'd3);
        cycle("untr_rd");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1) begin
                issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            end
            if ($urandom_range(0, 2) != 0) wb(5'($urandom_range(0, 31)), $urandom);
            cycle("rand");
        end

        idle();
        cycle("final");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
